uart_fifo_param: RTL and testbench

Parametrised synchronous FIFO for the UART TX and RX data paths. It generalises the fixed 16x8 TX FIFO in three ways: configurable width and depth, a programmable trigger-level flag, and sticky overflow/underflow error flags. It also adds a synchronous flush and a defined read-data value when empty. It sits between the APB register interface and the UART serialiser/deserialiser, one instance per direction.

---
 rtl/uart_fifo_pkg.sv | 16 +
 rtl/uart_fifo_param_if.sv | 34 +++
 rtl/uart_fifo_mem.sv | 24 ++
 rtl/uart_fifo_param.sv | 91 +++++++++
 tb/tb_uart_fifo_param.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_fifo_pkg.sv
// Shared constants and helpers for the UART data-path FIFOs.
package uart_fifo_pkg;

    localparam int UART_FIFO_WIDTH = 8;
    localparam int UART_FIFO_DEPTH = 16;

    // Widest occupancy/threshold field: DEPTH=256 needs 9 bits.
    localparam int LVL_W = 9;

    // Threshold compare; narrower fields are zero-extended by the caller.
    function automatic logic level_reached(input logic [LVL_W-1:0] cnt,
                                           input logic [LVL_W-1:0] trig);
        return cnt >= trig;
    endfunction

endpackage

// File: rtl/uart_fifo_param_if.sv
// FIFO handshake bundle between the register block and the FIFO core.
interface uart_fifo_param_if
    import uart_fifo_pkg::*;
#(
    parameter int WIDTH = UART_FIFO_WIDTH,
    parameter int DEPTH = UART_FIFO_DEPTH
);
    localparam int AW = $clog2(DEPTH);

    logic             flush;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] data_in;
    logic [AW:0]      trig_level;
    logic             err_clr;
    logic [WIDTH-1:0] data_out;
    logic             fifo_empty;
    logic             fifo_full;
    logic [AW:0]      count;
    logic             level_hit;
    logic             overflow;
    logic             underflow;

    modport master (
        output flush, push, pop, data_in, trig_level, err_clr,
        input  data_out, fifo_empty, fifo_full, count, level_hit, overflow, underflow
    );

    modport slave (
        input  flush, push, pop, data_in, trig_level, err_clr,
        output data_out, fifo_empty, fifo_full, count, level_hit, overflow, underflow
    );

endinterface

// File: rtl/uart_fifo_mem.sv
// FIFO storage: synchronous write, combinational read, contents not reset.
module uart_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write port: one word per cycle when enabled.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_fifo_param.sv
// Parametrised UART FIFO: pointers, occupancy, trigger flag, sticky errors.
module uart_fifo_param
    import uart_fifo_pkg::*;
#(
    parameter  int WIDTH = UART_FIFO_WIDTH,
    parameter  int DEPTH = UART_FIFO_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rstn,
    uart_fifo_param_if.slave   bus
);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             ovf_q, ovf_d, udf_q, udf_d;
    logic             full, empty, do_wr, do_rd, set_ovf, set_udf;
    logic [WIDTH-1:0] rdata;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);

    // Next state: flush beats push/pop; a pop on empty never blocks a push,
    // and a pop on full frees the slot the concurrent push takes.
    always_comb begin
        do_wr    = bus.push && !bus.flush && (!full || bus.pop);
        do_rd    = bus.pop && !bus.flush && !empty;
        set_ovf  = bus.push && full && !bus.pop && !bus.flush;
        set_udf  = bus.pop && empty && !bus.flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
        // Set wins over clear in the same cycle.
        ovf_d = set_ovf | (ovf_q & ~bus.err_clr);
        udf_d = set_udf | (udf_q & ~bus.err_clr);
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    uart_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk   (clk),
        .we    (do_wr),
        .waddr (wr_ptr_q),
        .wdata (bus.data_in),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    // Stale array contents are masked while empty.
    assign bus.data_out   = empty ? '0 : rdata;
    assign bus.fifo_empty = empty;
    assign bus.fifo_full  = full;
    assign bus.count      = count_q;
    assign bus.level_hit  = level_reached(LVL_W'(count_q), LVL_W'(bus.trig_level));
    assign bus.overflow   = ovf_q;
    assign bus.underflow  = udf_q;

    a_full:  assert property (@(posedge clk) disable iff (!rstn) full |-> count_q == (AW+1)'(DEPTH));
    a_empty: assert property (@(posedge clk) disable iff (!rstn) empty |-> count_q == '0);
    a_range: assert property (@(posedge clk) disable iff (!rstn) count_q <= (AW+1)'(DEPTH));
    a_ptrs:  assert property (@(posedge clk) disable iff (!rstn)
                 !empty |-> ((wr_ptr_q - rd_ptr_q) == count_q[AW-1:0]) &&
                            ((wr_ptr_q == rd_ptr_q) == full));
    a_ovf:   assert property (@(posedge clk) disable iff (!rstn)
                 $rose(ovf_q) |-> $past(bus.push && full && !bus.pop && !bus.flush));

endmodule

// File: tb/tb_uart_fifo_param.sv
// Bench for uart_fifo_param: queue reference model, directed plus random steps.
module tb_uart_fifo_param;

    localparam int D0 = 16;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    uart_fifo_param_if #(.WIDTH(8),  .DEPTH(16)) b0 ();
    uart_fifo_param_if #(.WIDTH(12), .DEPTH(4))  b1 ();

    uart_fifo_param #(.WIDTH(8),  .DEPTH(16)) u0 (.clk(clk), .rstn(rstn), .bus(b0));
    uart_fifo_param #(.WIDTH(12), .DEPTH(4))  u1 (.clk(clk), .rstn(rstn), .bus(b1));

    int total = 0;
    int bad   = 0;

    // Reference model of u0: a plain queue plus two sticky bits.
    logic [7:0] q0[$];
    logic       ovf0, udf0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit em, fu, so, su;
        em = (q0.size() == 0);
        fu = (q0.size() == D0);
        so = 0;
        su = 0;
        if (!b0.flush) begin
            if (b0.pop) begin
                if (em) su = 1;
                else void'(q0.pop_front());
            end
            if (b0.push) begin
                if (fu && !b0.pop) so = 1;
                else q0.push_back(b0.data_in);
            end
        end else begin
            q0.delete();
        end
        ovf0 = so | (ovf0 & ~b0.err_clr);
        udf0 = su | (udf0 & ~b0.err_clr);
    endtask

    task automatic chk_all(input string tag);
        logic [7:0] hd;
        hd = (q0.size() != 0) ? q0[0] : 8'h00;
        chk({tag, ":count"}, 32'(b0.count),      32'(q0.size()));
        chk({tag, ":empty"}, 32'(b0.fifo_empty), 32'(q0.size() == 0));
        chk({tag, ":full"},  32'(b0.fifo_full),  32'(q0.size() == D0));
        chk({tag, ":dout"},  32'(b0.data_out),   32'(hd));
        chk({tag, ":level"}, 32'(b0.level_hit),  32'(q0.size() >= int'(b0.trig_level)));
        chk({tag, ":ovf"},   32'(b0.overflow),   32'(ovf0));
        chk({tag, ":udf"},   32'(b0.underflow),  32'(udf0));
    endtask

    task automatic cyc(input string tag);
        model_step();
        @(posedge clk);
        #1;
        chk_all(tag);
    endtask

    task automatic idle0();
        b0.push = 0; b0.pop = 0; b0.flush = 0; b0.err_clr = 0;
    endtask

    initial begin
        logic [11:0] w[5];
        rstn = 1'b0;
        idle0();
        b0.data_in = 8'h00; b0.trig_level = 5'd0;
        b1.push = 0; b1.pop = 0; b1.flush = 0; b1.err_clr = 0;
        b1.data_in = 12'h000; b1.trig_level = 3'd3;
        ovf0 = 0; udf0 = 0;

        // Reset state while rstn is held low.
        #12;
        chk_all("rst");
        chk("rst1:count", 32'(b1.count),     32'd0);
        chk("rst1:empty", 32'(b1.fifo_empty), 32'd1);
        chk("rst1:level", 32'(b1.level_hit),  32'd0);
        #1 rstn = 1'b1;
        @(posedge clk); #1;

        // Three words in, three out, in order.
        foreach (w[i]) w[i] = 12'($urandom);
        b0.push = 1;
        b0.data_in = 8'h11; cyc("p11");
        b0.data_in = 8'h22; cyc("p22");
        b0.data_in = 8'h33; cyc("p33");
        chk("three:dout", 32'(b0.data_out), 32'h11);
        b0.push = 0; b0.pop = 1;
        repeat (3) cyc("pop3");
        chk("drained:dout", 32'(b0.data_out), 32'h00);
        idle0();

        // Fill to the top, then one more push that must be dropped.
        b0.push = 1;
        for (int i = 0; i < D0; i++) begin
            b0.data_in = 8'(i); cyc("fill");
        end
        b0.data_in = 8'hAA; cyc("push17");
        chk("push17:ovf",  32'(b0.overflow),  32'd1);
        chk("push17:full", 32'(b0.fifo_full), 32'd1);
        b0.push = 0; b0.pop = 1;
        for (int i = 0; i < D0; i++) begin
            chk("drain16:dout", 32'(b0.data_out), 32'(i));
            cyc("drain16");
        end
        idle0(); b0.err_clr = 1; cyc("clr"); idle0();

        // Full FIFO streaming: simultaneous push/pop wraps both pointers.
        b0.push = 1;
        for (int i = 0; i < D0; i++) begin
            b0.data_in = 8'($urandom); cyc("refill");
        end
        b0.pop = 1;
        for (int i = 0; i < 20; i++) begin
            b0.data_in = 8'($urandom); cyc("stream");
        end
        chk("stream:count", 32'(b0.count),    32'd16);
        chk("stream:ovf",   32'(b0.overflow), 32'd0);
        b0.push = 0;
        repeat (D0) cyc("drain");
        idle0();

        // Underflow, clear, and set-beats-clear.
        b0.pop = 1; cyc("udf");
        chk("udf:set", 32'(b0.underflow), 32'd1);
        b0.pop = 0; b0.err_clr = 1; cyc("udfclr");
        chk("udf:clr", 32'(b0.underflow), 32'd0);
        b0.pop = 1; cyc("udfboth");
        chk("udf:both", 32'(b0.underflow), 32'd1);
        idle0();

        // Trigger level at 4.
        b0.trig_level = 5'd4; b0.push = 1;
        repeat (3) begin b0.data_in = 8'($urandom); cyc("lvl"); end
        chk("lvl3", 32'(b0.level_hit), 32'd0);
        cyc("lvl4");
        chk("lvl4", 32'(b0.level_hit), 32'd1);
        b0.push = 0; b0.pop = 1; cyc("lvlpop");
        chk("lvlpop", 32'(b0.level_hit), 32'd0);
        repeat (3) cyc("lvldrain");
        idle0();

        // Flush with a concurrent push discards everything.
        b0.push = 1;
        repeat (5) begin b0.data_in = 8'($urandom); cyc("ld5"); end
        b0.flush = 1; b0.data_in = 8'hEE; cyc("flush");
        chk("flush:count", 32'(b0.count),     32'd0);
        chk("flush:udf",   32'(b0.underflow), 32'd1);
        b0.flush = 0; b0.push = 1; b0.data_in = 8'h5A; cyc("postflush");
        chk("postflush:dout", 32'(b0.data_out), 32'h5A);
        idle0();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            b0.push       = ($urandom_range(99) < 60);
            b0.pop        = ($urandom_range(99) < 50);
            b0.flush      = ($urandom_range(99) < 3);
            b0.err_clr    = ($urandom_range(99) < 6);
            b0.data_in    = 8'($urandom);
            if ($urandom_range(19) == 0) b0.trig_level = 5'($urandom_range(20));
            cyc("rnd");
        end
        idle0();

        // Narrow/shallow instance: fill, overflow, pop, then async reset mid-burst.
        b1.push = 1;
        for (int i = 0; i < 4; i++) begin
            b1.data_in = w[i]; cyc("u1fill");
            chk("u1:count", 32'(b1.count),     32'(i + 1));
            chk("u1:level", 32'(b1.level_hit), 32'(i + 1 >= 3));
        end
        chk("u1:full", 32'(b1.fifo_full), 32'd1);
        chk("u1:dout", 32'(b1.data_out),  32'(w[0]));
        b1.data_in = 12'hFFF; cyc("u1ovf");
        chk("u1:ovf",   32'(b1.overflow), 32'd1);
        chk("u1:cnt4",  32'(b1.count),    32'd4);
        b1.push = 0; b1.pop = 1; cyc("u1pop");
        chk("u1:dout1", 32'(b1.data_out), 32'(w[1]));
        chk("u1:cnt3",  32'(b1.count),    32'd3);
        b1.pop = 0; b1.push = 1; b1.data_in = w[4]; cyc("u1burst");
        chk("u1:cnt4b", 32'(b1.count),    32'd4);
        #2 rstn = 1'b0;
        q0.delete(); ovf0 = 0; udf0 = 0;
        #1;
        chk("ar:count", 32'(b1.count),      32'd0);
        chk("ar:empty", 32'(b1.fifo_empty), 32'd1);
        chk("ar:full",  32'(b1.fifo_full),  32'd0);
        chk("ar:dout",  32'(b1.data_out),   32'd0);
        chk("ar:level", 32'(b1.level_hit),  32'd0);
        chk("ar:ovf",   32'(b1.overflow),   32'd0);
        chk("ar:udf",   32'(b1.underflow),  32'd0);
        chk_all("ar0");
        b1.push = 0;
        #3 rstn = 1'b1;
        cyc("after");
        chk("after:u1count", 32'(b1.count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
